sha256d_engine: RTL and testbench

// Parametrised successor to the single-shot sha256 core. Accepts an 80-byte (640-bit) header
// or a pre-padded 512-bit block, pads internally, and runs one of three jobs:

---
 rtl/sha256d_engine.sv | 182 ++++++++++++++++++
 tb/tb_sha256d_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sha256d_engine.sv
`default_nettype none
// ============================================================================
// sha256d_engine : 80-byte header SHA-256 / SHA256d and raw one-block
//                  compression engine with valid/ready handshakes
// Revision : 1.0
// ============================================================================
module sha256d_engine #(
   parameter int UNROLL = 1,
   parameter bit OUT_LE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   mode,
   input  logic [639:0] block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] hash,
   output logic         busy
);

   generate
      if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
         $error("sha256d_engine: UNROLL must be 1, 2, 4 or 8");
      end
   endgenerate

   localparam logic [5:0]   LAST_RND = 6'(64 - UNROLL);
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0]  K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_OUT} state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] byterev(input logic [255:0] x);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
      return r;
   endfunction

   state_t       state_q, state_d;
   logic [5:0]   rnd_q, rnd_d;
   logic [1:0]   blk_q, blk_d;
   logic [1:0]   mode_q, mode_d;
   logic [127:0] tail_q, tail_d;
   logic [255:0] h_q, h_d, st_q, st_d, hash_q, hash_d;
   logic [511:0] win_q, win_d;

   logic [255:0] st_r, sum;
   logic [511:0] win_r;
   logic [31:0]  ra, rb, rc, rd, re, rf, rg, rh, t1, t2, wn;
   logic         last_blk;

   // UNROLL rounds chained combinationally; W window holds W[t]..W[t+15], W[t] in the MSBs
   always_comb begin
      st_r  = st_q;
      win_r = win_q;
      {ra, rb, rc, rd, re, rf, rg, rh} = '0;
      t1 = '0;
      t2 = '0;
      wn = '0;
      for (int j = 0; j < UNROLL; j++) begin
         {ra, rb, rc, rd, re, rf, rg, rh} = st_r;
         t1 = rh + (rotr(re, 6) ^ rotr(re, 11) ^ rotr(re, 25)) + ((re & rf) ^ (~re & rg))
              + K[rnd_q + 6'(j)] + win_r[511:480];
         t2 = (rotr(ra, 2) ^ rotr(ra, 13) ^ rotr(ra, 22)) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
         st_r = {t1 + t2, ra, rb, rc, rd + t1, re, rf, rg};
         wn = (rotr(win_r[63:32], 17) ^ rotr(win_r[63:32], 19) ^ (win_r[63:32] >> 10))
              + win_r[223:192]
              + (rotr(win_r[479:448], 7) ^ rotr(win_r[479:448], 18) ^ (win_r[479:448] >> 3))
              + win_r[511:480];
         win_r = {win_r[479:0], wn};
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < 8; i++) sum[32*i +: 32] = h_q[32*i +: 32] + st_q[32*i +: 32];
   end

   assign last_blk = mode_q[1] ? (blk_q == 2'd0) : (mode_q[0] ? (blk_q == 2'd2) : (blk_q == 2'd1));

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      blk_d   = blk_q;
      mode_d  = mode_q;
      tail_d  = tail_q;
      h_d     = h_q;
      st_d    = st_q;
      win_d   = win_q;
      hash_d  = hash_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               state_d = S_ROUND;
               mode_d  = mode;
               tail_d  = block[127:0];
               blk_d   = 2'd0;
               rnd_d   = '0;
               h_d     = IV;
               st_d    = IV;
               win_d   = block[639:128];
            end
         end
         S_ROUND: begin
            st_d  = st_r;
            win_d = win_r;
            rnd_d = rnd_q + 6'(UNROLL);
            if (rnd_q == LAST_RND) state_d = S_ADD;
         end
         S_ADD: begin
            h_d   = sum;
            blk_d = blk_q + 2'd1;
            rnd_d = '0;
            if (last_blk) begin
               state_d = S_OUT;
               hash_d  = OUT_LE ? byterev(sum) : sum;
            end else if (blk_q == 2'd0) begin
               state_d = S_ROUND;
               st_d    = sum;
               win_d   = {tail_q, 32'h80000000, 320'd0, 32'd640};
            end else begin
               // second pass of SHA256d hashes the first digest from a fresh IV
               state_d = S_ROUND;
               h_d     = IV;
               st_d    = IV;
               win_d   = {sum, 32'h80000000, 192'd0, 32'd256};
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rnd_q   <= '0;
         blk_q   <= '0;
         mode_q  <= '0;
         tail_q  <= '0;
         h_q     <= '0;
         st_q    <= '0;
         win_q   <= '0;
         hash_q  <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         blk_q   <= blk_d;
         mode_q  <= mode_d;
         tail_q  <= tail_d;
         h_q     <= h_d;
         st_q    <= st_d;
         win_q   <= win_d;
         hash_q  <= hash_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign busy      = !in_ready;
   assign out_valid = (state_q == S_OUT);
   assign hash      = hash_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256d_engine.sv
`default_nettype none
// ============================================================================
// tb_sha256d_engine : directed-vector bench over UNROLL 1/4/8 and OUT_LE builds
// Revision : 1.0
// ============================================================================
module tb_sha256d_engine;

   localparam logic [255:0] G      = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
   localparam logic [255:0] G_LE   = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
   localparam logic [255:0] ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] ABC_LE = 256'had1500f261ff10b49c7a1796a36103b02322ae5dde404141eacf018fbf1678ba;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic [639:0] block = '0;

   logic [3:0]   in_ready_v, out_valid_v, busy_v;
   logic [255:0] hash_v [4];

   int           n_checks = 0;
   int           n_pass = 0;
   int           lat [4];
   int           cyc_per_blk [4] = '{65, 65, 17, 9};

   logic [639:0] genesis, abc;
   logic [255:0] h1;
   logic         flag;

   always #5 clk = ~clk;

   sha256d_engine #(.UNROLL(1), .OUT_LE(1'b0)) u_u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .mode(mode),
      .block(block), .out_valid(out_valid_v[0]), .out_ready(out_ready), .hash(hash_v[0]), .busy(busy_v[0]));
   sha256d_engine #(.UNROLL(1), .OUT_LE(1'b1)) u_u1le (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .mode(mode),
      .block(block), .out_valid(out_valid_v[1]), .out_ready(out_ready), .hash(hash_v[1]), .busy(busy_v[1]));
   sha256d_engine #(.UNROLL(4), .OUT_LE(1'b0)) u_u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]), .mode(mode),
      .block(block), .out_valid(out_valid_v[2]), .out_ready(out_ready), .hash(hash_v[2]), .busy(busy_v[2]));
   sha256d_engine #(.UNROLL(8), .OUT_LE(1'b0)) u_u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[3]), .mode(mode),
      .block(block), .out_valid(out_valid_v[3]), .out_ready(out_ready), .hash(hash_v[3]), .busy(busy_v[3]));

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [1:0] m, input logic [639:0] b);
      mode     = m;
      block    = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // lat[k] = cycles from the accept edge until instance k shows out_valid (0 = never)
   task automatic wait_all(input int budget);
      int c;
      c = 0;
      for (int k = 0; k < 4; k++) lat[k] = 0;
      while (out_valid_v != 4'hF && c < budget) begin
         tick();
         c++;
         for (int k = 0; k < 4; k++) if (out_valid_v[k] && lat[k] == 0) lat[k] = c;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic job(input string tag, input logic [1:0] m, input logic [639:0] b, input int nblk,
                      input logic [255:0] hb, input logic [255:0] hl, input bit do_hs);
      start_job(m, b);
      check({tag, "_busy"}, {252'd0, busy_v}, 256'hF);
      wait_all(300);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_lat%0d", tag, k), 256'(lat[k]), 256'(nblk * cyc_per_blk[k]));
         check($sformatf("%s_hash%0d", tag, k), hash_v[k], (k == 1) ? hl : hb);
      end
      if (do_hs) begin
         handshake();
         check({tag, "_ovalid_clr"}, {252'd0, out_valid_v}, 256'h0);
         check({tag, "_iready_set"}, {252'd0, in_ready_v}, 256'hF);
      end
   endtask

   initial begin
      genesis = {32'h01000000, 256'h0,
                 256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
                 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
      abc     = {32'h61626380, 448'h0, 32'h00000018, 128'hdeadbeef_cafef00d_01234567_89abcdef};

      // reset state
      repeat (3) tick();
      check("rst_iready", {252'd0, in_ready_v}, 256'h0);
      check("rst_busy", {252'd0, busy_v}, 256'hF);
      check("rst_ovalid", {252'd0, out_valid_v}, 256'h0);
      check("rst_hash", hash_v[0], 256'h0);
      rst = 1'b0;
      #1;
      check("post_rst_iready", {252'd0, in_ready_v}, 256'hF);

      // genesis SHA256d, then hold the result under backpressure
      job("gen", 2'b01, genesis, 3, G, G_LE, 1'b0);
      flag = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) in_valid = 1'b1;
         if (i == 5) in_valid = 1'b0;
         mode  = 2'b10;
         block = abc;
         tick();
         if (hash_v[0] !== G || hash_v[1] !== G_LE || out_valid_v != 4'hF || in_ready_v != 4'h0)
            flag = 1'b0;
      end
      check("bp_stable", {255'd0, flag}, 256'd1);
      handshake();
      check("bp_ovalid_clr", {252'd0, out_valid_v}, 256'h0);
      check("bp_iready_set", {252'd0, in_ready_v}, 256'hF);
      flag = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (out_valid_v != 4'h0 || in_ready_v != 4'hF) flag = 1'b0;
      end
      check("bp_pulse_ignored", {255'd0, flag}, 256'd1);

      // raw compression, both raw encodings
      job("abc10", 2'b10, abc, 1, ABC, ABC_LE, 1'b1);
      job("abc11", 2'b11, abc, 1, ABC, ABC_LE, 1'b1);

      // single SHA-256 of the header; its digest re-hashed raw must give the genesis hash
      start_job(2'b00, genesis);
      wait_all(300);
      for (int k = 0; k < 4; k++)
         check($sformatf("sha_lat%0d", k), 256'(lat[k]), 256'(2 * cyc_per_blk[k]));
      h1 = hash_v[0];
      handshake();
      job("rehash", 2'b10, {h1, 32'h80000000, 192'h0, 32'd256, 128'h0}, 1, G, G_LE, 1'b1);

      // abort mid-job
      start_job(2'b01, genesis);
      repeat (30) tick();
      rst = 1'b1;
      tick();
      check("abort_iready_rst", {252'd0, in_ready_v}, 256'h0);
      rst = 1'b0;
      #1;
      check("abort_iready_after", {252'd0, in_ready_v}, 256'hF);
      flag = 1'b1;
      for (int i = 0; i < 220; i++) begin
         tick();
         if (out_valid_v != 4'h0) flag = 1'b0;
      end
      check("abort_no_result", {255'd0, flag}, 256'd1);
      job("abc_after_abort", 2'b10, abc, 1, ABC, ABC_LE, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
